// File: rtl/operand_decode_if.sv
// Handshake and data bundle between the decoder, the instruction source,
// writeback and the execute stage.
interface operand_decode_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [5:0]        func;
  logic [4:0]        sa;
  logic [4:0]        rd;
  logic              illegal;

  modport master (
    output instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
    input  instr_ready, ex_valid, rs, rt, func, sa, rd, illegal
  );

  modport slave (
    input  instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
    output instr_ready, ex_valid, rs, rt, func, sa, rd, illegal
  );
endinterface

// File: rtl/operand_decode.sv
// R-type operand decode: register file, per-register outstanding-write
// counters for RAW stalls, and a one-deep registered output stage.
module operand_decode #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input logic           clock,
  input logic           reset,
  operand_decode_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] regs_r [32];
  logic [CNT_W-1:0]  cnt_r  [32];
  logic [DATA_W-1:0] rs_r;
  logic [DATA_W-1:0] rt_r;
  logic [5:0]        func_r;
  logic [4:0]        sa_r;
  logic [4:0]        rd_r;
  logic              illegal_r;

  logic [5:0]        opcode_s;
  logic [4:0]        rs_idx_s;
  logic [4:0]        rt_idx_s;
  logic [4:0]        rd_idx_s;
  logic              is_rtype_s;
  logic              rs_busy_s;
  logic              rt_busy_s;
  logic              hazard_s;
  logic              sat_s;
  logic              ready_s;
  logic              accept_s;
  logic              issue_s;
  logic              inc_s;
  logic              dec_s;
  logic [31:0]       inc_vec_s;
  logic [31:0]       dec_vec_s;
  logic [DATA_W-1:0] rs_val_s;
  logic [DATA_W-1:0] rt_val_s;

  assign opcode_s   = bus.instr[31:26];
  assign rs_idx_s   = bus.instr[25:21];
  assign rt_idx_s   = bus.instr[20:16];
  assign rd_idx_s   = bus.instr[15:11];
  assign is_rtype_s = (opcode_s == 6'd0);

  // A source whose last outstanding write retires this very cycle is not a hazard.
  assign rs_busy_s = (rs_idx_s != 5'd0) && (cnt_r[rs_idx_s] != {CNT_W{1'b0}}) &&
                     !(bus.wb_en && (bus.wb_addr == rs_idx_s) && (cnt_r[rs_idx_s] == CNT_ONE));
  assign rt_busy_s = (rt_idx_s != 5'd0) && (cnt_r[rt_idx_s] != {CNT_W{1'b0}}) &&
                     !(bus.wb_en && (bus.wb_addr == rt_idx_s) && (cnt_r[rt_idx_s] == CNT_ONE));
  assign hazard_s  = bus.instr_valid && is_rtype_s && (rs_busy_s || rt_busy_s);
  assign sat_s     = is_rtype_s && (rd_idx_s != 5'd0) && (cnt_r[rd_idx_s] == CNT_MAX) &&
                     !(bus.wb_en && (bus.wb_addr == rd_idx_s));

  assign ready_s   = ((state_r == EMPTY) || bus.ex_ready) && !hazard_s && !sat_s;
  assign accept_s  = bus.instr_valid && ready_s;
  assign issue_s   = accept_s && is_rtype_s;
  assign inc_s     = issue_s && (rd_idx_s != 5'd0);
  assign dec_s     = bus.wb_en && (bus.wb_addr != 5'd0);

  // Write-first read: a same-cycle writeback is forwarded to the operand.
  assign rs_val_s = (rs_idx_s == 5'd0) ? {DATA_W{1'b0}} :
                    (bus.wb_en && (bus.wb_addr == rs_idx_s)) ? bus.wb_data : regs_r[rs_idx_s];
  assign rt_val_s = (rt_idx_s == 5'd0) ? {DATA_W{1'b0}} :
                    (bus.wb_en && (bus.wb_addr == rt_idx_s)) ? bus.wb_data : regs_r[rt_idx_s];

  // One-hot increment/decrement selects for the counter bank.
  always_comb begin
    inc_vec_s = 32'd0;
    dec_vec_s = 32'd0;
    if (inc_s) begin
      inc_vec_s[rd_idx_s] = 1'b1;
    end else begin
      inc_vec_s = 32'd0;
    end
    if (dec_s) begin
      dec_vec_s[bus.wb_addr] = 1'b1;
    end else begin
      dec_vec_s = 32'd0;
    end
  end

  // Outstanding-write counters; a simultaneous inc and dec cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (inc_vec_s[i] && !dec_vec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (dec_vec_s[i] && !inc_vec_s[i] && (cnt_r[i] != {CNT_W{1'b0}})) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else if (dec_s) begin
      regs_r[bus.wb_addr] <= bus.wb_data;
    end else begin
      regs_r[bus.wb_addr] <= regs_r[bus.wb_addr];
    end
  end

  // Output stage FSM with its registered payload and illegal pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= EMPTY;
      rs_r      <= {DATA_W{1'b0}};
      rt_r      <= {DATA_W{1'b0}};
      func_r    <= 6'd0;
      sa_r      <= 5'd0;
      rd_r      <= 5'd0;
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= accept_s && !is_rtype_s;
      // issue_s already implies the stage is empty or being drained.
      if (issue_s) begin
        rs_r   <= rs_val_s;
        rt_r   <= rt_val_s;
        func_r <= bus.instr[5:0];
        sa_r   <= bus.instr[10:6];
        rd_r   <= rd_idx_s;
      end else begin
        rs_r   <= rs_r;
        rt_r   <= rt_r;
        func_r <= func_r;
        sa_r   <= sa_r;
        rd_r   <= rd_r;
      end
      case (state_r)
        EMPTY: begin
          if (issue_s) begin
            state_r <= FULL;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (bus.ex_ready && !issue_s) begin
            state_r <= EMPTY;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_s;
  assign bus.ex_valid    = (state_r == FULL);
  assign bus.rs          = rs_r;
  assign bus.rt          = rt_r;
  assign bus.func        = func_r;
  assign bus.sa          = sa_r;
  assign bus.rd          = rd_r;
  assign bus.illegal     = illegal_r;
endmodule

// File: tb/tb_operand_decode.sv
// Randomized plus directed bench for operand_decode: a reference model predicts
// handshakes and pushes expected issues; a monitor compares what execute sees.
module tb_operand_decode;
  localparam int CNT_MAX = 3;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  func;
    logic [4:0]  sa;
    logic [4:0]  rd;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  operand_decode_if #(.DATA_W(32)) bus();
  operand_decode #(.DATA_W(32), .CNT_W(2)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_full;
  bit          m_ill;
  bit          m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 0;
    end
    m_full = 1'b0;
    m_ill  = 1'b0;
    m_acc  = 1'b0;
    sb_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit wbe,
                                         input logic [4:0] wba, input logic [31:0] wbd);
    if (idx == 5'd0) return 32'd0;
    if (wbe && wba == idx) return wbd;
    return m_regs[idx];
  endfunction

  function automatic bit m_busy(input logic [4:0] idx, input bit wbe, input logic [4:0] wba);
    return (idx != 5'd0) && (m_pend[idx] != 0) && !(wbe && wba == idx && m_pend[idx] == 1);
  endfunction

  // One clock: drive inputs, predict and check handshakes at the falling edge, advance the model.
  task automatic step(input bit iv, input logic [31:0] ins, input bit wbe,
                      input logic [4:0] wba, input logic [31:0] wbd, input bit exr);
    logic [5:0] op;
    logic [4:0] a, b, d;
    bit haz, sat, rdy, rtype;
    int inc, dec;
    exp_t e;
    bus.instr_valid = iv;
    bus.instr       = ins;
    bus.wb_en       = wbe;
    bus.wb_addr     = wba;
    bus.wb_data     = wbd;
    bus.ex_ready    = exr;
    @(negedge clock);
    op = ins[31:26]; a = ins[25:21]; b = ins[20:16]; d = ins[15:11];
    rtype = (op == 6'd0);
    haz = iv && rtype && (m_busy(a, wbe, wba) || m_busy(b, wbe, wba));
    sat = rtype && d != 5'd0 && m_pend[d] == CNT_MAX && !(wbe && wba == d);
    rdy = (!m_full || exr) && !haz && !sat;
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_full});
    chk("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
    chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, rdy});
    m_acc = iv && rdy;
    if (m_acc && rtype) begin
      e.rs = m_read(a, wbe, wba, wbd);
      e.rt = m_read(b, wbe, wba, wbd);
      e.func = ins[5:0];
      e.sa = ins[10:6];
      e.rd = d;
      sb_q.push_back(e);
    end
    m_full = (m_acc && rtype) ? 1'b1 : (exr ? 1'b0 : m_full);
    m_ill  = m_acc && !rtype;
    inc = (m_acc && rtype && d != 5'd0) ? int'(d) : -1;
    dec = (wbe && wba != 5'd0) ? int'(wba) : -1;
    if (!(inc >= 0 && inc == dec)) begin
      if (inc >= 0) m_pend[inc]++;
      if (dec >= 0 && m_pend[dec] > 0) m_pend[dec]--;
    end
    if (wbe && wba != 5'd0) m_regs[wba] = wbd;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: whatever execute sees must be the oldest predicted issue.
  always @(negedge clock) begin
    if (!reset && bus.ex_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: ex_valid with rd=%0d, expected no pending issue", bus.rd);
      end else begin
        mon_e = sb_q[0];
        chk("sb_rs", bus.rs, mon_e.rs);
        chk("sb_rt", bus.rt, mon_e.rt);
        chk("sb_func", {26'd0, bus.func}, {26'd0, mon_e.func});
        chk("sb_sa", {27'd0, bus.sa}, {27'd0, mon_e.sa});
        chk("sb_rd", {27'd0, bus.rd}, {27'd0, mon_e.rd});
        if (bus.ex_ready) void'(sb_q.pop_front());
      end
    end
  end

  localparam logic [31:0] ADD3  = 32'h0022_1820;
  localparam logic [31:0] ADDU4 = 32'h0061_2021;
  localparam logic [31:0] ADD5  = 32'h0022_2820;
  localparam logic [31:0] ADD6  = 32'h0022_3020;
  localparam logic [31:0] R0R0  = 32'h0000_3020;
  localparam logic [31:0] LW    = 32'h8C22_0004;

  initial begin
    logic [31:0] ins;
    bit done;
    bus.instr_valid = 1'b0; bus.instr = 32'd0; bus.wb_en = 1'b0;
    bus.wb_addr = 5'd0; bus.wb_data = 32'd0; bus.ex_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("rst_rs", bus.rs, 32'd0);
    chk("rst_rd", {27'd0, bus.rd}, 32'd0);
    reset = 1'b0;

    // Basic issue with writeback-filled sources
    step(1'b0, 32'd0, 1'b1, 5'd1, 32'd5, 1'b1);
    step(1'b0, 32'd0, 1'b1, 5'd2, 32'd7, 1'b1);
    step(1'b1, ADD3, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t1_rs", bus.rs, 32'd5);
    chk("t1_rt", bus.rt, 32'd7);
    chk("t1_func", {26'd0, bus.func}, 32'h20);
    chk("t1_rd", {27'd0, bus.rd}, 32'd3);
    step(1'b0, 32'd0, 1'b1, 5'd3, 32'd12, 1'b1);

    // RAW stall released by a clearing writeback with bypass
    step(1'b1, ADD3, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (3) step(1'b1, ADDU4, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, ADDU4, 1'b1, 5'd3, 32'd12, 1'b1);
    chk("t2_rs", bus.rs, 32'd12);

    // Backpressure holds the stage; queued instruction follows
    repeat (5) step(1'b1, ADD6, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, ADD6, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // Counter saturation on rd=5
    repeat (3) step(1'b1, ADD5, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (2) step(1'b1, ADD5, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, ADD5, 1'b1, 5'd5, 32'd99, 1'b1);
    repeat (3) step(1'b1, ADD5, 1'b0, 5'd0, 32'd0, 1'b1);

    // Non-R-type drop and r0 write suppression
    step(1'b1, LW, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t5_illegal", {31'd0, bus.illegal}, 32'd1);
    chk("t5_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    step(1'b0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, R0R0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t5_r0_rs", bus.rs, 32'd0);
    chk("t5_r0_rt", bus.rt, 32'd0);
    repeat (4) step(1'b0, 32'd0, 1'b1, 5'd5, 32'd1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 5'd6, 32'd2, 1'b1);

    // Asynchronous reset while FULL with two writes pending on r3
    step(1'b1, ADD3, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, ADD3, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("t6_rs", bus.rs, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b1, ADDU4, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t6_rs_after", bus.rs, 32'd0);

    // Randomized traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 300; n++) begin
      ins = {(($urandom % 10) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
             5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
             5'($urandom % 32), 6'($urandom % 64)};
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        bit iv;
        iv = (($urandom % 10) != 0);
        step(iv, ins, (($urandom % 5) < 2), 5'($urandom % 8), $urandom, (($urandom % 4) != 0));
        if (iv && m_acc) done = 1'b1;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: instr 0x%0h got no acceptance, expected within 200 cycles", ins);
      end
    end
    repeat (4) step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
